// File: rtl/imem_fetch_sequencer.sv
// Arbitrates CPU instruction fetches and program-loader byte writes onto a single
// byte-wide instruction memory, assembling four bytes into a big-endian word.
module imem_fetch_sequencer #(
  parameter int IM_SIZE = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_CAP,
    S_RESP,
    S_WR,
    S_ERR
  } state_t;

  localparam logic [31:0] IM_LIMIT = 32'(IM_SIZE);

  state_t            state_q, state_d;
  logic              last_load_q, last_load_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [7:0]        ld_data_q, ld_data_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       instr_q, instr_d;

  logic grant_fetch;
  logic grant_load;
  logic fetch_bad;

  // On a tie the requester that did not win the previous grant goes first.
  assign grant_fetch = fetch_req && (!load_req || last_load_q);
  assign grant_load  = load_req && (!fetch_req || !last_load_q);
  assign fetch_bad   = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= IM_LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_load_q <= 1'b0;
      addr_q      <= '0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      word_q      <= '0;
      instr_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_load_q <= last_load_d;
      addr_q      <= addr_d;
      ld_addr_q   <= ld_addr_d;
      ld_data_q   <= ld_data_d;
      word_q      <= word_d;
      instr_q     <= instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_load_d = last_load_q;
    case (state_q)
      S_IDLE: begin
        if (grant_fetch) begin
          last_load_d = 1'b0;
          state_d     = fetch_bad ? S_ERR : S_RD0;
        end else if (grant_load) begin
          last_load_d = 1'b1;
          state_d     = S_WR;
        end
      end
      S_RD0:   state_d = S_RD1;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_RD3;
      S_RD3:   state_d = S_CAP;
      S_CAP:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_WR:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data trails the address by one cycle, so byte k lands while in RD(k+1)/CAP.
  always_comb begin
    addr_d    = addr_q;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
    word_d    = word_q;
    instr_d   = instr_q;
    case (state_q)
      S_IDLE: begin
        if (grant_fetch) begin
          addr_d = fetch_addr[ADDR_W-1:0];
          if (fetch_bad) begin
            instr_d = '0;
          end
        end else if (grant_load) begin
          ld_addr_d = load_addr;
          ld_data_d = load_data;
        end
      end
      S_RD1, S_RD2, S_RD3: word_d = {word_q[15:0], mem_rdata};
      S_CAP:               instr_d = {word_q, mem_rdata};
      default: ;
    endcase
  end

  always_comb begin
    fetch_valid = 1'b0;
    fetch_err   = 1'b0;
    load_ack    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      S_RD0: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
      end
      S_RD1: begin
        mem_en   = 1'b1;
        mem_addr = addr_q + ADDR_W'(1);
      end
      S_RD2: begin
        mem_en   = 1'b1;
        mem_addr = addr_q + ADDR_W'(2);
      end
      S_RD3: begin
        mem_en   = 1'b1;
        mem_addr = addr_q + ADDR_W'(3);
      end
      S_RESP: fetch_valid = 1'b1;
      S_ERR: begin
        fetch_valid = 1'b1;
        fetch_err   = 1'b1;
      end
      S_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr_q;
        mem_wdata = ld_data_q;
        load_ack  = 1'b1;
      end
      default: ;
    endcase
  end

  assign fetch_instr = instr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: a byte memory model answers the DUT, while a
// separate shadow copy of memory contents predicts every fetched word and timing.
module tb_imem_fetch_sequencer;
  localparam int IM_SIZE = 1024;
  localparam int ADDR_W  = 10;

  logic              clock = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic              fetch_err;
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              load_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  int checks = 0;
  int fails  = 0;

  logic [7:0] ref_mem [IM_SIZE];
  logic [7:0] env_mem [IM_SIZE];
  bit         env_wr  [IM_SIZE];
  logic [7:0] seed;

  always #5 clock = ~clock;

  imem_fetch_sequencer #(.IM_SIZE(IM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [7:0] pattern(int a);
    return 8'(a * 29) ^ 8'(a >> 3) ^ seed;
  endfunction

  // Byte memory seen by the DUT: unwritten locations return a fixed pattern.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        env_mem[mem_addr] <= mem_wdata;
        env_wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : pattern(int'(mem_addr));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a);
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  task automatic do_fetch(input logic [31:0] a, input bit drop_early, input string tag);
    bit exp_err, got, bus_bad, busy_bad, rd_bad;
    logic [31:0] exp_instr;
    int exp_lat, n, rd_cnt;
    exp_err   = (a[1:0] != 2'b00) || (a >= 32'(IM_SIZE));
    exp_instr = exp_err ? 32'h0 : ref_word(a);
    exp_lat   = exp_err ? 1 : 6;
    fetch_req  = 1'b1;
    fetch_addr = a;
    n = 0; rd_cnt = 0; got = 0; bus_bad = 0; busy_bad = 0; rd_bad = 0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (drop_early) fetch_req = 1'b0;
      if (mem_en === 1'b1) begin
        if (mem_we !== 1'b0 || mem_addr !== ADDR_W'(a + 32'(rd_cnt))) rd_bad = 1;
        rd_cnt++;
      end else if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
        bus_bad = 1;
      end
      if (busy !== 1'b1 || load_ack !== 1'b0) busy_bad = 1;
      if (fetch_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got || n != exp_lat) begin
      fails++;
      $display("[TB] FAIL %s latency: got %0d cycles (valid=%0b) expected %0d", tag, n, got, exp_lat);
    end
    checks++;
    if (fetch_err !== exp_err || fetch_instr !== exp_instr) begin
      fails++;
      $display("[TB] FAIL %s response: got err=%0b instr=%h expected err=%0b instr=%h",
               tag, fetch_err, fetch_instr, exp_err, exp_instr);
    end
    checks++;
    if (rd_bad || rd_cnt != (exp_err ? 0 : 4)) begin
      fails++;
      $display("[TB] FAIL %s reads: got %0d reads (bad=%0b) expected %0d", tag, rd_cnt, rd_bad,
               exp_err ? 0 : 4);
    end
    checks++;
    if (bus_bad || busy_bad) begin
      fails++;
      $display("[TB] FAIL %s bus/busy: got bus_bad=%0b busy_bad=%0b expected 0/0", tag, bus_bad, busy_bad);
    end
    fetch_req = 1'b0;
    tick();
    checks++;
    if (fetch_instr !== exp_instr || busy !== 1'b0 || fetch_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s hold: got instr=%h busy=%0b valid=%0b expected instr=%h busy=0 valid=0",
               tag, fetch_instr, busy, fetch_valid, exp_instr);
    end
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [7:0] d, input string tag);
    int n;
    bit got, bus_ok;
    load_req = 1'b1; load_addr = a; load_data = d;
    n = 0; got = 0; bus_ok = 0;
    while (!got && n < 10) begin
      tick();
      n++;
      if (load_ack === 1'b1) begin
        got = 1;
        bus_ok = (mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === a && mem_wdata === d);
      end
    end
    if (got) ref_mem[a] = d;
    load_req = 1'b0;
    checks++;
    if (!got || n != 1 || !bus_ok) begin
      fails++;
      $display("[TB] FAIL %s load: got ack=%0b after %0d cycles bus_ok=%0b expected ack after 1 with bus_ok=1",
               tag, got, n, bus_ok);
    end
    tick();
    checks++;
    if (load_ack !== 1'b0 || busy !== 1'b0) begin
      fail_msg: begin
        fails++;
        $display("[TB] FAIL %s post-load: got ack=%0b busy=%0b expected 0/0", tag, load_ack, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_req = 1'b0; load_req = 1'b0;
    fetch_addr = '0; load_addr = '0; load_data = '0;
    tick(); tick();
    checks++;
    if ({fetch_valid, fetch_err, load_ack, mem_en, mem_we, busy} !== 6'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || fetch_instr !== '0) begin
      fails++;
      $display("[TB] FAIL reset outputs: got v=%0b e=%0b ack=%0b en=%0b we=%0b busy=%0b addr=%h wd=%h instr=%h expected all 0",
               fetch_valid, fetch_err, load_ack, mem_en, mem_we, busy, mem_addr, mem_wdata, fetch_instr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_known_word();
    do_load(10'h000, 8'h8C, "known_ld0");
    do_load(10'h001, 8'h22, "known_ld1");
    do_load(10'h002, 8'h00, "known_ld2");
    do_load(10'h003, 8'h04, "known_ld3");
    do_fetch(32'h0, 1'b0, "known_fetch");
    checks++;
    if (fetch_instr !== 32'h8C220004) begin
      fails++;
      $display("[TB] FAIL known_word: got %h expected 8c220004", fetch_instr);
    end
  endtask

  task automatic test_errors();
    do_fetch(32'h0000_0006, 1'b0, "misaligned");
    do_fetch(32'h0000_0400, 1'b0, "out_of_range");
    do_fetch(32'h0000_03FC, 1'b0, "last_word");
    do_fetch(32'hFFFF_FFF0, 1'b0, "high_addr");
  endtask

  task automatic test_drop_early();
    do_fetch(32'h0000_0020, 1'b1, "drop_early");
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    logic [31:0] w1, w2;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    n1 = 0;
    do begin tick(); n1++; end while (fetch_valid !== 1'b1 && n1 < 20);
    w1 = fetch_instr;
    fetch_addr = 32'h104;
    n2 = 0;
    do begin tick(); n2++; end while (fetch_valid !== 1'b1 && n2 < 20);
    w2 = fetch_instr;
    fetch_req = 1'b0;
    tick();
    checks++;
    if (n1 != 6 || n2 != 7) begin
      fails++;
      $display("[TB] FAIL back_to_back timing: got %0d,%0d cycles expected 6,7", n1, n2);
    end
    checks++;
    if (w1 !== ref_word(32'h100) || w2 !== ref_word(32'h104)) begin
      fails++;
      $display("[TB] FAIL back_to_back data: got %h,%h expected %h,%h", w1, w2,
               ref_word(32'h100), ref_word(32'h104));
    end
  endtask

  task automatic test_arbitration();
    int exp_t [6];
    bit exp_ld [6];
    int obs_t [$];
    bit obs_ld [$];
    int t;
    bit g_load, data_bad;
    t = 0; g_load = 1; data_bad = 0;
    for (int k = 0; k < 6; k++) begin
      exp_ld[k] = g_load;
      if (g_load) begin exp_t[k] = t + 1; t += 2; end
      else begin exp_t[k] = t + 6; t += 7; end
      g_load = !g_load;
    end
    reset = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'h10;
    load_req = 1'b1; load_addr = 10'h021; load_data = 8'hA5;
    tick(); tick();
    reset = 1'b0;
    for (int cyc = 1; cyc <= 27; cyc++) begin
      tick();
      if (load_ack === 1'b1) begin
        ref_mem[10'h021] = 8'hA5;
        obs_t.push_back(cyc); obs_ld.push_back(1'b1);
      end
      if (fetch_valid === 1'b1) begin
        if (fetch_instr !== ref_word(32'h10) || fetch_err !== 1'b0) data_bad = 1;
        obs_t.push_back(cyc); obs_ld.push_back(1'b0);
      end
    end
    fetch_req = 1'b0; load_req = 1'b0;
    tick(); tick();
    checks++;
    if (obs_t.size() != 6) begin
      fails++;
      $display("[TB] FAIL arbitration count: got %0d grants expected 6", obs_t.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (obs_t[k] != exp_t[k] || obs_ld[k] != exp_ld[k]) begin
          fails++;
          $display("[TB] FAIL arbitration event %0d: got cycle %0d load=%0b expected cycle %0d load=%0b",
                   k, obs_t[k], obs_ld[k], exp_t[k], exp_ld[k]);
        end
      end
    end
    checks++;
    if (data_bad) begin
      fails++;
      $display("[TB] FAIL arbitration data: got wrong fetched word expected %h", ref_word(32'h10));
    end
  endtask

  task automatic test_load_during_fetch();
    logic [31:0] old_w, got_w;
    logic [7:0] new_b;
    int valid_n, ack_n;
    old_w = ref_word(32'h40);
    new_b = ~ref_mem[10'h041];
    valid_n = 0; ack_n = 0; got_w = '0;
    fetch_req = 1'b1; fetch_addr = 32'h40;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 2) begin
        load_req = 1'b1; load_addr = 10'h041; load_data = new_b;
      end
      if (fetch_valid === 1'b1) begin
        valid_n = n; got_w = fetch_instr; fetch_req = 1'b0;
      end
      if (load_ack === 1'b1) begin
        ack_n = n; load_req = 1'b0; ref_mem[10'h041] = new_b;
      end
    end
    checks++;
    if (valid_n != 6 || ack_n != 8) begin
      fails++;
      $display("[TB] FAIL load_during_fetch order: got valid@%0d ack@%0d expected valid@6 ack@8", valid_n, ack_n);
    end
    checks++;
    if (got_w !== old_w) begin
      fails++;
      $display("[TB] FAIL load_during_fetch word: got %h expected %h", got_w, old_w);
    end
    do_fetch(32'h40, 1'b0, "after_load");
  endtask

  task automatic test_reset_mid_fetch();
    bit saw_valid;
    fetch_req = 1'b1; fetch_addr = 32'h80;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({fetch_valid, fetch_err, load_ack, mem_en, mem_we, busy} !== 6'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || fetch_instr !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_fetch outputs: got v=%0b en=%0b busy=%0b addr=%h instr=%h expected all 0",
               fetch_valid, mem_en, busy, mem_addr, fetch_instr);
    end
    reset = 1'b0; fetch_req = 1'b0;
    saw_valid = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (fetch_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1;
    end
    checks++;
    if (saw_valid) begin
      fails++;
      $display("[TB] FAIL reset_mid_fetch abandon: got activity after reset expected none");
    end
    do_fetch(32'h80, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int sel;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_load(ADDR_W'($urandom_range(0, IM_SIZE - 1)), 8'($urandom), "rand_load");
      end else begin
        sel = $urandom_range(0, 19);
        if (sel < 14)      a = 32'($urandom_range(0, IM_SIZE / 4 - 1)) << 2;
        else if (sel < 17) a = (32'($urandom_range(0, IM_SIZE / 4 - 1)) << 2) | 32'($urandom_range(1, 3));
        else               a = 32'($urandom_range(IM_SIZE, 32'h0000_FFFF)) & 32'hFFFF_FFFC;
        do_fetch(a, 1'($urandom_range(0, 1)), "rand_fetch");
      end
    end
  endtask

  initial begin
    #500_000;
    fails++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    seed = 8'($urandom);
    for (int i = 0; i < IM_SIZE; i++) ref_mem[i] = pattern(i);
    test_reset();
    test_known_word();
    test_errors();
    test_drop_early();
    test_back_to_back();
    test_arbitration();
    test_load_during_fetch();
    test_reset_mid_fetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
